// File: rtl/dp_pipe_pkg.sv
// Shared constants and helpers for the multi-precision FP operand pipeline.
package dp_pipe_pkg;

  localparam int LANES_DEF  = 4;
  localparam int EXP_W_DEF  = 8;
  localparam int MAN_W_DEF  = 13;
  localparam int MODE_W_DEF = 2;

  localparam logic [1:0] MODE_LOW = 2'b00;
  localparam logic [1:0] MODE_SP  = 2'b01;
  localparam logic [1:0] MODE_DP  = 2'b10;

  // Any mode other than low-only carries a meaningful high mantissa half;
  // the reserved code 11 therefore behaves like double.
  function automatic logic hi_en(input logic [1:0] mode);
    return (mode != MODE_LOW);
  endfunction

endpackage

// File: rtl/dp_operand_skid_reg_if.sv
// Valid/ready operand beat bus: handshake plus packed sign/exp/mantissa fields.
interface dp_operand_skid_reg_if
  import dp_pipe_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MAN_W  = MAN_W_DEF,
  parameter int MODE_W = MODE_W_DEF
);
  logic                       valid;
  logic                       ready;
  logic [MODE_W-1:0]          mode;
  logic [2*LANES-1:0]         sign;
  logic [2*LANES*EXP_W-1:0]   exp;
  logic [2*LANES*MAN_W-1:0]   high;
  logic [2*LANES*MAN_W-1:0]   low;

  modport master (output valid, mode, sign, exp, high, low, input ready);
  modport slave  (input valid, mode, sign, exp, high, low, output ready);

endinterface

// File: rtl/dp_operand_entry.sv
// One operand field-set register. The high mantissa half has its own load
// enable so low-only beats leave it untouched instead of gating its clock.
module dp_operand_entry
  import dp_pipe_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MAN_W  = MAN_W_DEF,
  parameter int MODE_W = MODE_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     hi_load,
  input  logic [MODE_W-1:0]        d_mode,
  input  logic [2*LANES-1:0]       d_sign,
  input  logic [2*LANES*EXP_W-1:0] d_exp,
  input  logic [2*LANES*MAN_W-1:0] d_high,
  input  logic [2*LANES*MAN_W-1:0] d_low,
  output logic [MODE_W-1:0]        q_mode,
  output logic [2*LANES-1:0]       q_sign,
  output logic [2*LANES*EXP_W-1:0] q_exp,
  output logic [2*LANES*MAN_W-1:0] q_high,
  output logic [2*LANES*MAN_W-1:0] q_low
);

  // Always-loaded fields: mode, sign, exponent, low mantissa half.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_mode <= '0;
      q_sign <= '0;
      q_exp  <= '0;
      q_low  <= '0;
    end else if (load) begin
      q_mode <= d_mode;
      q_sign <= d_sign;
      q_exp  <= d_exp;
      q_low  <= d_low;
    end
  end

  // High mantissa half: written only for beats whose precision uses it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_high <= '0;
    end else if (hi_load) begin
      q_high <= d_high;
    end
  end

endmodule

// File: rtl/dp_operand_skid_reg.sv
// Operand pipeline stage with a 2-entry skid buffer. Entry M drives the
// outputs, entry S absorbs one beat of backpressure so in_ready is a flop.
module dp_operand_skid_reg
  import dp_pipe_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MAN_W  = MAN_W_DEF,
  parameter int MODE_W = MODE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  dp_operand_skid_reg_if.slave  in_bus,
  dp_operand_skid_reg_if.master out_bus
);

  localparam int SW = 2*LANES;
  localparam int EW = 2*LANES*EXP_W;
  localparam int MW = 2*LANES*MAN_W;

  logic m_valid, s_valid, in_ready_q;
  logic m_valid_nxt, s_valid_nxt;
  logic accept, pop;
  logic m_load, m_sel_s, s_load;
  logic m_hi_load, s_hi_load;

  logic [MODE_W-1:0] s_mode, m_d_mode;
  logic [SW-1:0]     s_sign, m_d_sign;
  logic [EW-1:0]     s_exp,  m_d_exp;
  logic [MW-1:0]     s_high, m_d_high;
  logic [MW-1:0]     s_low,  m_d_low;

  assign accept = in_bus.valid & in_ready_q;
  assign pop    = m_valid & out_bus.ready;

  assign in_bus.ready  = in_ready_q;
  assign out_bus.valid = m_valid;

  // Skid control: decide which entry loads and the next valid bits.
  always_comb begin
    m_load      = 1'b0;
    m_sel_s     = 1'b0;
    s_load      = 1'b0;
    m_valid_nxt = m_valid;
    s_valid_nxt = s_valid;
    if (flush) begin
      m_valid_nxt = 1'b0;
      s_valid_nxt = 1'b0;
    end else if (!m_valid || pop) begin
      if (s_valid) begin
        m_load      = 1'b1;
        m_sel_s     = 1'b1;
        m_valid_nxt = 1'b1;
        s_valid_nxt = 1'b0;
      end else if (accept) begin
        m_load      = 1'b1;
        m_valid_nxt = 1'b1;
      end else begin
        m_valid_nxt = 1'b0;
      end
    end else if (accept) begin
      // in_ready is low whenever S is full, so this never overwrites S.
      s_load      = 1'b1;
      s_valid_nxt = 1'b1;
    end
  end

  // M takes the skid entry when it holds a beat, otherwise the input.
  always_comb begin
    m_d_mode = m_sel_s ? s_mode : in_bus.mode;
    m_d_sign = m_sel_s ? s_sign : in_bus.sign;
    m_d_exp  = m_sel_s ? s_exp  : in_bus.exp;
    m_d_high = m_sel_s ? s_high : in_bus.high;
    m_d_low  = m_sel_s ? s_low  : in_bus.low;
  end

  assign m_hi_load = m_load & hi_en(m_d_mode);
  assign s_hi_load = s_load & hi_en(in_bus.mode);

  // Valid bits and the registered in_ready (mirror of the next S.valid).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_valid    <= m_valid_nxt;
      s_valid    <= s_valid_nxt;
      in_ready_q <= ~s_valid_nxt;
    end
  end

  dp_operand_entry #(
    .LANES(LANES), .EXP_W(EXP_W), .MAN_W(MAN_W), .MODE_W(MODE_W)
  ) u_entry_m (
    .clk     (clk),
    .rst     (rst),
    .load    (m_load),
    .hi_load (m_hi_load),
    .d_mode  (m_d_mode),
    .d_sign  (m_d_sign),
    .d_exp   (m_d_exp),
    .d_high  (m_d_high),
    .d_low   (m_d_low),
    .q_mode  (out_bus.mode),
    .q_sign  (out_bus.sign),
    .q_exp   (out_bus.exp),
    .q_high  (out_bus.high),
    .q_low   (out_bus.low)
  );

  dp_operand_entry #(
    .LANES(LANES), .EXP_W(EXP_W), .MAN_W(MAN_W), .MODE_W(MODE_W)
  ) u_entry_s (
    .clk     (clk),
    .rst     (rst),
    .load    (s_load),
    .hi_load (s_hi_load),
    .d_mode  (in_bus.mode),
    .d_sign  (in_bus.sign),
    .d_exp   (in_bus.exp),
    .d_high  (in_bus.high),
    .d_low   (in_bus.low),
    .q_mode  (s_mode),
    .q_sign  (s_sign),
    .q_exp   (s_exp),
    .q_high  (s_high),
    .q_low   (s_low)
  );

endmodule

// File: tb/tb_dp_operand_skid_reg.sv
// Self-checking bench for the operand skid register stage.
module tb_dp_operand_skid_reg;
  import dp_pipe_pkg::*;

  localparam int LANES = 4;
  localparam int EXP_W = 8;
  localparam int MAN_W = 13;
  localparam int NOP   = 2*LANES;

  typedef struct packed {
    logic [1:0]             mode;
    logic [NOP-1:0]         sign;
    logic [NOP*EXP_W-1:0]   exp;
    logic [NOP*MAN_W-1:0]   high;
    logic [NOP*MAN_W-1:0]   low;
  } beat_t;

  typedef struct {
    bit         iv, ordy, fl;
    logic [1:0] mode;
    logic [7:0] tag;
    logic [12:0] hi;
    bit         ov, ir;
    logic [1:0] omode;
    logic [7:0] otag;
    logic [12:0] ohi;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  dp_operand_skid_reg_if #(.LANES(LANES), .EXP_W(EXP_W), .MAN_W(MAN_W), .MODE_W(2)) in_if ();
  dp_operand_skid_reg_if #(.LANES(LANES), .EXP_W(EXP_W), .MAN_W(MAN_W), .MODE_W(2)) out_if ();

  dp_operand_skid_reg #(.LANES(LANES), .EXP_W(EXP_W), .MAN_W(MAN_W), .MODE_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .in_bus  (in_if.slave),
    .out_bus (out_if.master)
  );

  always #5 clk = ~clk;

  // Payload derived from a tag: x1 exponent equals the tag.
  function automatic beat_t make_beat(input logic [7:0] tag, input logic [1:0] mode,
                                      input logic [12:0] hi);
    beat_t b;
    b.mode = mode;
    b.sign = tag;
    for (int i = 0; i < NOP; i++) begin
      b.exp[i*EXP_W +: EXP_W]  = tag + 8'(i) - 8'd1;
      b.high[i*MAN_W +: MAN_W] = hi ^ 13'(i);
      b.low[i*MAN_W +: MAN_W]  = {5'(i), tag};
    end
    return b;
  endfunction

  function automatic beat_t got_beat();
    return {out_if.mode, out_if.sign, out_if.exp, out_if.high, out_if.low};
  endfunction

  task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic drive(input bit iv, input bit ordy, input bit fl, input beat_t b);
    in_if.valid  = iv;
    out_if.ready = ordy;
    flush        = fl;
    in_if.mode   = b.mode;
    in_if.sign   = b.sign;
    in_if.exp    = b.exp;
    in_if.high   = b.high;
    in_if.low    = b.low;
  endtask

  vec_t vt[$];

  task automatic add(input bit iv, ordy, fl, input logic [1:0] mode, input logic [7:0] tag,
                     input logic [12:0] hi, input bit ov, ir, input logic [1:0] omode,
                     input logic [7:0] otag, input logic [12:0] ohi);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.mode = mode; v.tag = tag; v.hi = hi;
    v.ov = ov; v.ir = ir; v.omode = omode; v.otag = otag; v.ohi = ohi;
    vt.push_back(v);
  endtask

  beat_t q[$];
  beat_t e, g, snap;
  bit    stall_prev;
  int    popped, cyc;
  bit    acc, pp, fl_r;

  initial begin
    // Reset held with random activity on the inputs.
    for (int c = 0; c < 4; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
            make_beat(8'($urandom), 2'($urandom), 13'($urandom)));
      @(posedge clk); #1;
      chk("rst_out_valid", 300'(out_if.valid), 300'(1'b0));
      chk("rst_in_ready", 300'(in_if.ready), 300'(1'b1));
      chk("rst_fields", 300'(got_beat()), 300'(0));
    end
    drive(0, 1, 0, make_beat(0, 0, 0));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle_valid", 300'(out_if.valid), 300'(1'b0));

    // Streaming, 1-cycle latency.
    for (int k = 1; k <= 8; k++)
      add(1, 1, 0, MODE_DP, 8'(k), 13'(k + 256), 1, 1, MODE_DP, 8'(k), 13'(k + 256));
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Backpressure, skid fill, drain in order.
    add(1, 0, 0, MODE_DP, 8'h21, 13'h221, 1, 1, MODE_DP, 8'h21, 13'h221);
    add(1, 0, 0, MODE_DP, 8'h22, 13'h222, 1, 0, MODE_DP, 8'h21, 13'h221);
    add(1, 0, 0, MODE_DP, 8'h23, 13'h223, 1, 0, MODE_DP, 8'h21, 13'h221);
    add(1, 1, 0, MODE_DP, 8'h23, 13'h223, 1, 1, MODE_DP, 8'h22, 13'h222);
    add(1, 1, 0, MODE_DP, 8'h23, 13'h223, 1, 1, MODE_DP, 8'h23, 13'h223);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // High-half gating on the direct input path.
    add(1, 1, 0, MODE_DP,  8'h31, 13'h1ABC, 1, 1, MODE_DP,  8'h31, 13'h1ABC);
    add(1, 1, 0, MODE_LOW, 8'h32, 13'h0555, 1, 1, MODE_LOW, 8'h32, 13'h1ABC);
    add(1, 1, 0, 2'b11,    8'h33, 13'h0777, 1, 1, 2'b11,    8'h33, 13'h0777);
    add(1, 1, 0, MODE_SP,  8'h34, 13'h0123, 1, 1, MODE_SP,  8'h34, 13'h0123);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // High-half gating on the S -> M move.
    add(1, 0, 0, MODE_DP,  8'h41, 13'h0AAA, 1, 1, MODE_DP,  8'h41, 13'h0AAA);
    add(1, 0, 0, MODE_LOW, 8'h42, 13'h0555, 1, 0, MODE_DP,  8'h41, 13'h0AAA);
    add(0, 1, 0, 0, 0, 0, 1, 1, MODE_LOW, 8'h42, 13'h0AAA);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Flush with both entries full and a beat offered, then with stage empty.
    add(1, 0, 0, MODE_DP, 8'h51, 13'h251, 1, 1, MODE_DP, 8'h51, 13'h251);
    add(1, 0, 0, MODE_DP, 8'h52, 13'h252, 1, 0, MODE_DP, 8'h51, 13'h251);
    add(1, 0, 1, MODE_DP, 8'h53, 13'h253, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, 1, MODE_DP, 8'h54, 13'h254, 0, 1, 0, 0, 0);
    add(1, 1, 0, MODE_DP, 8'h55, 13'h255, 1, 1, MODE_DP, 8'h55, 13'h255);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    foreach (vt[i]) begin
      drive(vt[i].iv, vt[i].ordy, vt[i].fl, make_beat(vt[i].tag, vt[i].mode, vt[i].hi));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 300'(out_if.valid), 300'(vt[i].ov));
      chk($sformatf("vec%0d_in_ready", i), 300'(in_if.ready), 300'(vt[i].ir));
      if (vt[i].ov)
        chk($sformatf("vec%0d_beat", i), 300'(got_beat()),
            300'(make_beat(vt[i].otag, vt[i].omode, vt[i].ohi)));
    end

    // Reset in the middle of a transfer with both entries full.
    drive(1, 0, 0, make_beat(8'h61, MODE_DP, 13'h261));
    @(posedge clk); #1;
    drive(1, 0, 0, make_beat(8'h62, MODE_DP, 13'h262));
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 300'(out_if.valid), 300'(1'b0));
    chk("midrst_in_ready", 300'(in_if.ready), 300'(1'b1));
    chk("midrst_fields", 300'(got_beat()), 300'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1, 1, 0, make_beat(8'h63, MODE_SP, 13'h263));
    @(posedge clk); #1;
    chk("midrst_first_valid", 300'(out_if.valid), 300'(1'b1));
    chk("midrst_first_beat", 300'(got_beat()), 300'(make_beat(8'h63, MODE_SP, 13'h263)));
    drive(0, 1, 0, make_beat(0, 0, 0));
    @(posedge clk); #1;

    // Random handshake traffic against a FIFO scoreboard.
    stall_prev = 1'b0;
    popped = 0;
    cyc = 0;
    while (popped < 10000 && cyc < 60000) begin
      cyc++;
      if (stall_prev) chk("stall_stable", 300'(got_beat()), 300'(snap));
      fl_r = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, fl_r,
            make_beat(8'($urandom), 2'($urandom), 13'($urandom)));
      #1;
      acc = in_if.valid & in_if.ready;
      pp  = out_if.valid & out_if.ready;
      g   = got_beat();
      if (fl_r) begin
        q.delete();
        stall_prev = 1'b0;
      end else begin
        if (pp) begin
          if (q.size() == 0) begin
            chk("sb_unexpected_pop", 300'(1'b1), 300'(1'b0));
          end else begin
            e = q.pop_front();
            if (e.mode == MODE_LOW) begin
              e.high = '0;
              g.high = '0;
            end
            chk("sb_beat", 300'(g), 300'(e));
            popped++;
          end
        end
        if (acc) q.push_back(make_beat(in_if.sign, in_if.mode, in_if.high[MAN_W-1:0]));
        stall_prev = out_if.valid & ~out_if.ready;
        snap = got_beat();
      end
      @(posedge clk); #1;
    end
    chk("sb_beat_count", 300'(popped >= 10000), 300'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
